// File: rtl/fifo_pkg.sv
// Shared definitions for the multi-port FIFO: sizing helpers and default geometry.
package fifo_pkg;

    // Ceiling log2, usable in parameter expressions.
    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r++;
            v = v >> 1;
        end
        return r;
    endfunction

    // True when value is a non-zero power of two.
    function automatic bit is_pow2(input int value);
        return (value > 0) && ((value & (value - 1)) == 0);
    endfunction

    localparam int  FIFO_SIZE_DEF     = 16;
    localparam bit  FIFO_SIZE_DEF_OK  = is_pow2(FIFO_SIZE_DEF);

endpackage

// File: rtl/fifo_mp_ptr.sv
// Wrap-bit pointer that advances by a variable step (0..PORTS) per cycle.
module fifo_mp_ptr #(
    parameter int PTR_W  = 5,
    parameter int STEP_W = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              en,
    input  logic [STEP_W-1:0] step,
    output logic [PTR_W-1:0]  ptr
);

    // Reset and flush both return the pointer to zero; otherwise advance on accept.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            ptr <= '0;
        end else if (en) begin
            ptr <= ptr + PTR_W'(step);
        end
    end

endmodule

// File: rtl/fifo_mp.sv
// Multi-port first-word-fall-through FIFO with all-or-nothing push/pop acceptance.
module fifo_mp
    import fifo_pkg::*;
#(
    parameter int FIFO_DATA_WIDTH = 32,
    parameter int FIFO_SIZE       = FIFO_SIZE_DEF,
    parameter int FIFO_SIZE_WIDTH = 4,
    parameter int WR_PORTS        = 2,
    parameter int RD_PORTS        = 2,
    parameter int PORT_CNT_WIDTH  = 2,
    parameter int AFULL_MARGIN    = 2
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 flush_i,
    input  logic [PORT_CNT_WIDTH-1:0]            wr_cnt_i,
    input  logic [WR_PORTS*FIFO_DATA_WIDTH-1:0]  wdata_i,
    output logic                                 wr_acc_o,
    input  logic [PORT_CNT_WIDTH-1:0]            rd_cnt_i,
    output logic [RD_PORTS*FIFO_DATA_WIDTH-1:0]  rdata_o,
    output logic [RD_PORTS-1:0]                  rd_vld_o,
    output logic                                 rd_acc_o,
    output logic [FIFO_SIZE_WIDTH:0]             fifo_num_o,
    output logic                                 fifo_full_o,
    output logic                                 fifo_empty_o,
    output logic                                 almost_full_o
);

    localparam int PTR_W = FIFO_SIZE_WIDTH + 1;
    localparam int AW    = FIFO_SIZE_WIDTH;
    localparam int W     = FIFO_DATA_WIDTH;
    localparam logic [PTR_W-1:0] SIZE_P   = PTR_W'(FIFO_SIZE);
    localparam logic [PTR_W-1:0] MARGIN_P = PTR_W'(AFULL_MARGIN);

    localparam bit SIZE_OK = is_pow2(FIFO_SIZE) && FIFO_SIZE_DEF_OK
                             && (FIFO_SIZE_WIDTH == clog2(FIFO_SIZE))
                             && (FIFO_SIZE >= WR_PORTS) && (FIFO_SIZE >= RD_PORTS)
                             && ((1 << PORT_CNT_WIDTH) > WR_PORTS)
                             && ((1 << PORT_CNT_WIDTH) > RD_PORTS);

    if (!SIZE_OK) begin : g_bad_geometry
        $error("fifo_mp: FIFO_SIZE must be a power of two matching FIFO_SIZE_WIDTH and port counts");
    end

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] num;
    logic [PTR_W-1:0] free;
    logic [W-1:0]     mem [FIFO_SIZE];

    // Occupancy and acceptance come from start-of-cycle pointers only; a pop never frees
    // space for a push in the same cycle.
    always_comb begin
        num          = wr_ptr - rd_ptr;
        free         = SIZE_P - num;
        wr_acc_o     = (wr_cnt_i != '0) && (PTR_W'(wr_cnt_i) <= free) && !flush_i;
        rd_acc_o     = (rd_cnt_i != '0) && (PTR_W'(rd_cnt_i) <= num) && !flush_i;
        fifo_num_o   = num;
        fifo_full_o  = (num == SIZE_P);
        fifo_empty_o = (num == '0);
        almost_full_o = (free <= MARGIN_P);
    end

    fifo_mp_ptr #(.PTR_W(PTR_W), .STEP_W(PORT_CNT_WIDTH)) u_wr_ptr (
        .clk   (clk),
        .rst   (rst),
        .flush (flush_i),
        .en    (wr_acc_o),
        .step  (wr_cnt_i),
        .ptr   (wr_ptr)
    );

    fifo_mp_ptr #(.PTR_W(PTR_W), .STEP_W(PORT_CNT_WIDTH)) u_rd_ptr (
        .clk   (clk),
        .rst   (rst),
        .flush (flush_i),
        .en    (rd_acc_o),
        .step  (rd_cnt_i),
        .ptr   (rd_ptr)
    );

    // Storage write decoder: lanes below wr_cnt_i land at consecutive wrapped slots.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < FIFO_SIZE; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_acc_o) begin
            for (int j = 0; j < WR_PORTS; j++) begin
                if (PORT_CNT_WIDTH'(j) < wr_cnt_i) begin
                    mem[wr_ptr[AW-1:0] + AW'(j)] <= wdata_i[j*W +: W];
                end
            end
        end
    end

    // Fall-through read muxes: head entries always visible, lane 0 is oldest.
    always_comb begin
        rdata_o  = '0;
        rd_vld_o = '0;
        for (int k = 0; k < RD_PORTS; k++) begin
            rdata_o[k*W +: W] = mem[rd_ptr[AW-1:0] + AW'(k)];
            rd_vld_o[k]       = (PTR_W'(k) < num);
        end
    end

endmodule

// File: tb/tb_fifo_mp.sv
// Directed bench for fifo_mp with a queue-based reference model checked every cycle.
module tb_fifo_mp;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush_i;
    logic [1:0]  wr_cnt_i;
    logic [63:0] wdata_i;
    logic        wr_acc_o;
    logic [1:0]  rd_cnt_i;
    logic [63:0] rdata_o;
    logic [1:0]  rd_vld_o;
    logic        rd_acc_o;
    logic [4:0]  fifo_num_o;
    logic        fifo_full_o;
    logic        fifo_empty_o;
    logic        almost_full_o;

    int nvec = 0;
    int nerr = 0;

    fifo_mp dut (
        .clk          (clk),
        .rst          (rst),
        .flush_i      (flush_i),
        .wr_cnt_i     (wr_cnt_i),
        .wdata_i      (wdata_i),
        .wr_acc_o     (wr_acc_o),
        .rd_cnt_i     (rd_cnt_i),
        .rdata_o      (rdata_o),
        .rd_vld_o     (rd_vld_o),
        .rd_acc_o     (rd_acc_o),
        .fifo_num_o   (fifo_num_o),
        .fifo_full_o  (fifo_full_o),
        .fifo_empty_o (fifo_empty_o),
        .almost_full_o(almost_full_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: an ordered list of stored words.
    logic [31:0] q[$];
    bit          model_ok = 0;

    function automatic bit exp_wacc();
        return (wr_cnt_i != 0) && (int'(wr_cnt_i) <= 16 - q.size()) && !flush_i;
    endfunction

    function automatic bit exp_racc();
        return (rd_cnt_i != 0) && (int'(rd_cnt_i) <= q.size()) && !flush_i;
    endfunction

    // Model update on the clock edge, from the inputs held over that edge.
    always @(posedge clk) begin
        bit wa, ra;
        wa = exp_wacc();
        ra = exp_racc();
        if (rst) begin
            q.delete();
            model_ok = 1;
        end else if (flush_i) begin
            q.delete();
        end else begin
            if (ra) for (int k = 0; k < int'(rd_cnt_i); k++) void'(q.pop_front());
            if (wa) begin
                if (wr_cnt_i >= 1) q.push_back(wdata_i[31:0]);
                if (wr_cnt_i >= 2) q.push_back(wdata_i[63:32]);
            end
        end
    end

    // Compare process, away from the active edge.
    always @(negedge clk) begin
        if (model_ok && !rst) begin
            int n;
            logic [1:0] vld;
            n = q.size();
            vld = {n > 1, n > 0};
            assert (wr_cnt_i <= 2 && rd_cnt_i <= 2) else $error("illegal request count");
            chk("m_num",   fifo_num_o, n);
            chk("m_full",  fifo_full_o, n == 16);
            chk("m_empty", fifo_empty_o, n == 0);
            chk("m_afull", almost_full_o, (16 - n) <= 2);
            chk("m_vld",   rd_vld_o, vld);
            chk("m_wacc",  wr_acc_o, exp_wacc());
            chk("m_racc",  rd_acc_o, exp_racc());
            if (n > 0) chk("m_lane0", rdata_o[31:0], q[0]);
            if (n > 1) chk("m_lane1", rdata_o[63:32], q[1]);
        end
    end

    logic last_wacc, last_racc;

    // One cycle: drive at posedge+1, sample acceptance, then step past the next edge.
    task automatic step(input logic [1:0] wc, input logic [31:0] d0, input logic [31:0] d1,
                        input logic [1:0] rc, input logic fl);
        wr_cnt_i = wc;
        wdata_i  = {d1, d0};
        rd_cnt_i = rc;
        flush_i  = fl;
        #1;
        last_wacc = wr_acc_o;
        last_racc = rd_acc_o;
        @(posedge clk);
        #1;
        wr_cnt_i = 0;
        rd_cnt_i = 0;
        flush_i  = 0;
        wdata_i  = '0;
    endtask

    initial begin
        rst = 1; flush_i = 0; wr_cnt_i = 0; rd_cnt_i = 0; wdata_i = '0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 0;

        // 1. reset values and single lane
        chk("rst_num",   fifo_num_o, 0);
        chk("rst_empty", fifo_empty_o, 1);
        chk("rst_full",  fifo_full_o, 0);
        chk("rst_afull", almost_full_o, 0);
        chk("rst_vld",   rd_vld_o, 0);
        chk("rst_rdata", rdata_o, 0);
        step(1, 32'hA0, 32'h0, 0, 0);
        chk("t1_wacc",  last_wacc, 1);
        chk("t1_num",   fifo_num_o, 1);
        chk("t1_vld",   rd_vld_o, 2'b01);
        chk("t1_lane0", rdata_o[31:0], 32'hA0);
        step(0, 0, 0, 1, 0);
        chk("t1_racc",  last_racc, 1);
        chk("t1_empty", fifo_empty_o, 1);

        // 2. dual fill
        for (int i = 0; i < 8; i++) begin
            step(2, 32'h100 + 2*i, 32'h101 + 2*i, 0, 0);
            chk("t2_num",   fifo_num_o, 2*(i+1));
            chk("t2_afull", almost_full_o, (i >= 6));
        end
        chk("t2_full", fifo_full_o, 1);
        chk("t2_n16",  fifo_num_o, 16);

        // 3. reject when full, all-or-nothing at 15
        step(1, 32'hDEAD, 0, 0, 0);
        chk("t3_wacc_full", last_wacc, 0);
        chk("t3_num",       fifo_num_o, 16);
        chk("t3_lane0",     rdata_o[31:0], 32'h100);
        step(0, 0, 0, 1, 0);
        step(2, 32'hBEEF, 32'hBEEF, 0, 0);
        chk("t3_wacc_15", last_wacc, 0);
        chk("t3_num15",   fifo_num_o, 15);
        chk("t3_head",    rdata_o[31:0], 32'h101);
        step(0, 0, 0, 0, 1);
        chk("t3_flush", fifo_num_o, 0);

        // 4. simultaneous push and pop
        step(2, 32'hB1, 32'hB2, 0, 0);
        step(1, 32'hB3, 0, 0, 0);
        step(2, 32'hB4, 32'hB5, 2, 0);
        chk("t4_wacc",  last_wacc, 1);
        chk("t4_racc",  last_racc, 1);
        chk("t4_num",   fifo_num_o, 3);
        chk("t4_lanes", rdata_o, {32'hB4, 32'hB3});
        step(0, 0, 0, 2, 0);
        chk("t4_last", rdata_o[31:0], 32'hB5);
        step(0, 0, 0, 1, 0);
        chk("t4_empty", fifo_empty_o, 1);

        // 5. wrap: bring both pointers to 15
        step(0, 0, 0, 0, 1);
        for (int i = 0; i < 7; i++) step(2, 32'h200 + i, 32'h300 + i, 0, 0);
        step(1, 32'h2FF, 0, 0, 0);
        for (int i = 0; i < 7; i++) step(0, 0, 0, 2, 0);
        step(0, 0, 0, 1, 0);
        chk("t5_empty", fifo_empty_o, 1);
        step(2, 32'h11, 32'h22, 0, 0);
        chk("t5_mem15", dut.mem[15], 32'h11);
        chk("t5_mem0",  dut.mem[0], 32'h22);
        chk("t5_lanes", rdata_o, {32'h22, 32'h11});
        step(0, 0, 0, 2, 0);
        chk("t5_racc",  last_racc, 1);
        chk("t5_empty2", fifo_empty_o, 1);

        // 6. flush with push, then reset during pop
        step(2, 32'hC1, 32'hC2, 0, 0);
        step(2, 32'hC3, 32'hC4, 0, 0);
        step(1, 32'hC5, 0, 0, 0);
        chk("t6_num5", fifo_num_o, 5);
        step(2, 32'hE1, 32'hE2, 0, 1);
        chk("t6_wacc",  last_wacc, 0);
        chk("t6_num0",  fifo_num_o, 0);
        step(2, 32'hF1, 32'hF2, 0, 0);
        rst = 1;
        step(0, 0, 0, 1, 0);
        rst = 0;
        chk("t6_num",   fifo_num_o, 0);
        chk("t6_empty", fifo_empty_o, 1);
        chk("t6_full",  fifo_full_o, 0);
        chk("t6_afull", almost_full_o, 0);
        chk("t6_vld",   rd_vld_o, 0);
        chk("t6_rdata", rdata_o, 0);
        @(posedge clk); #1;

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
